i2c_slave_controller: RTL

I2C target (slave) counterpart to the team's I2C master controller. It watches SCL/SDA, detects START/STOP and its 7-bit address, and receives write bytes into the fabric. It serves read bytes supplied by the fabric and drives ACK/NACK on SDA. It never stretches SCL and supports standard and fast mode (up to 400 kHz) with a 50 MHz system clock.

---
 rtl/i2c_slave_controller.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_controller.sv
// I2C target: filtered SCL/SDA front end, START/STOP and 7-bit address detection,
// byte receive into the fabric and byte transmit from the fabric, open-drain SDA.
`timescale 1ns/1ps
module i2c_slave_controller #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       master_nack,
    output logic       start_det,
    output logic       stop_det,
    output logic       addressed,
    output logic       rw
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX_BYTE,
        ST_RX_ACK, ST_TX_BYTE, ST_TX_ACK, ST_WAIT_STOP
    } state_t;

    localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

    // Index 0 is SCL, index 1 is SDA throughout the front end.
    logic [1:0] meta_q, sync_q, filt_q, filt_prev_q;
    logic [3:0] flt_cnt_q [2];

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       full_q, full_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       sda_en_q, sda_en_d;
    logic       rw_q, rw_d;
    logic       addressed_q, addressed_d;
    logic       ack_q, ack_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_pend_q, rx_pend_d;
    logic       rx_valid_q;
    logic       tx_req_q, tx_req_d;
    logic       master_nack_q, master_nack_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;

    logic scl_f_s, sda_f_s, scl_rise_s, scl_fall_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s, addr_match_s;

    // Synchronize both bus lines and require FILTER_LEN stable samples before the filtered copy moves.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q       <= 2'b11;
            sync_q       <= 2'b11;
            filt_q       <= 2'b11;
            filt_prev_q  <= 2'b11;
            flt_cnt_q[0] <= 4'd0;
            flt_cnt_q[1] <= 4'd0;
        end else begin
            meta_q      <= {i2c_sda, i2c_scl};
            sync_q      <= meta_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    flt_cnt_q[i] <= 4'd0;
                end else if (flt_cnt_q[i] == FLT_LAST) begin
                    filt_q[i]    <= sync_q[i];
                    flt_cnt_q[i] <= 4'd0;
                end else begin
                    flt_cnt_q[i] <= flt_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    assign scl_f_s      = filt_q[0];
    assign sda_f_s      = filt_q[1];
    assign scl_rise_s   =  filt_q[0] & ~filt_prev_q[0];
    assign scl_fall_s   = ~filt_q[0] &  filt_prev_q[0];
    assign sda_rise_s   =  filt_q[1] & ~filt_prev_q[1];
    assign sda_fall_s   = ~filt_q[1] &  filt_prev_q[1];
    assign start_s      = sda_fall_s & scl_f_s;
    assign stop_s       = sda_rise_s & scl_f_s;
    // Address 0 (general call) never matches.
    assign addr_match_s = (shift_q[7:1] == SLAVE_ADDR) && (SLAVE_ADDR != 7'h00);

    // Protocol FSM: START/STOP override every state, otherwise act on filtered SCL edges.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        full_d        = full_q;
        shift_d       = shift_q;
        tx_shift_d    = tx_shift_q;
        sda_en_d      = sda_en_q;
        rw_d          = rw_q;
        addressed_d   = addressed_q;
        ack_d         = ack_q;
        rx_data_d     = rx_data_q;
        rx_pend_d     = 1'b0;
        tx_req_d      = 1'b0;
        master_nack_d = 1'b0;
        start_det_d   = 1'b0;
        stop_det_d    = 1'b0;
        if (start_s) begin
            start_det_d = 1'b1;
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd0;
            full_d      = 1'b0;
            addressed_d = 1'b0;
            sda_en_d    = 1'b0;
        end else if (stop_s) begin
            stop_det_d  = 1'b1;
            state_d     = ST_IDLE;
            sda_en_d    = 1'b0;
            addressed_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_RX_BYTE: begin
                    if (scl_rise_s) begin
                        shift_d   = {shift_q[6:0], sda_f_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            full_d = 1'b1;
                            if (state_q == ST_RX_BYTE) begin
                                rx_data_d = {shift_q[6:0], sda_f_s};
                                rx_pend_d = 1'b1;
                            end else begin
                                rx_data_d = rx_data_q;
                            end
                        end else begin
                            full_d = full_q;
                        end
                    end else if (scl_fall_s && full_q) begin
                        full_d = 1'b0;
                        if (state_q == ST_RX_BYTE) begin
                            sda_en_d = rx_ack;
                            ack_d    = rx_ack;
                            state_d  = ST_RX_ACK;
                        end else if (addr_match_s) begin
                            sda_en_d = 1'b1;
                            rw_d     = shift_q[0];
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            sda_en_d = 1'b0;
                            state_d  = ST_WAIT_STOP;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise_s) begin
                        addressed_d = 1'b1;
                        tx_req_d    = rw_q;
                    end else if (scl_fall_s) begin
                        bit_cnt_d = 3'd0;
                        if (rw_q) begin
                            sda_en_d   = ~tx_data[7];
                            tx_shift_d = {tx_data[6:0], 1'b0};
                            bit_cnt_d  = 3'd1;
                            state_d    = ST_TX_BYTE;
                        end else begin
                            sda_en_d = 1'b0;
                            state_d  = ST_RX_BYTE;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall_s) begin
                        sda_en_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = ack_q ? ST_RX_BYTE : ST_WAIT_STOP;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_TX_BYTE: begin
                    // bit_cnt counts bits already presented; wrapping to 0 means bit 0 is on the bus.
                    if (scl_fall_s && (bit_cnt_q == 3'd0)) begin
                        sda_en_d = 1'b0;
                        state_d  = ST_TX_ACK;
                    end else if (scl_fall_s) begin
                        sda_en_d   = ~tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise_s && !sda_f_s) begin
                        tx_req_d = 1'b1;
                    end else if (scl_rise_s) begin
                        master_nack_d = 1'b1;
                        state_d       = ST_WAIT_STOP;
                    end else if (scl_fall_s) begin
                        sda_en_d   = ~tx_data[7];
                        tx_shift_d = {tx_data[6:0], 1'b0};
                        bit_cnt_d  = 3'd1;
                        state_d    = ST_TX_BYTE;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: state_d = state_q;
                default:               state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            full_q        <= 1'b0;
            shift_q       <= 8'h00;
            tx_shift_q    <= 8'h00;
            sda_en_q      <= 1'b0;
            rw_q          <= 1'b0;
            addressed_q   <= 1'b0;
            ack_q         <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_pend_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            tx_req_q      <= 1'b0;
            master_nack_q <= 1'b0;
            start_det_q   <= 1'b0;
            stop_det_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            full_q        <= full_d;
            shift_q       <= shift_d;
            tx_shift_q    <= tx_shift_d;
            sda_en_q      <= sda_en_d;
            rw_q          <= rw_d;
            addressed_q   <= addressed_d;
            ack_q         <= ack_d;
            rx_data_q     <= rx_data_d;
            rx_pend_q     <= rx_pend_d;
            rx_valid_q    <= rx_pend_q;
            tx_req_q      <= tx_req_d;
            master_nack_q <= master_nack_d;
            start_det_q   <= start_det_d;
            stop_det_q    <= stop_det_d;
        end
    end

    assign i2c_sda     = sda_en_q ? 1'b0 : 1'bz;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_req      = tx_req_q;
    assign master_nack = master_nack_q;
    assign start_det   = start_det_q;
    assign stop_det    = stop_det_q;
    assign addressed   = addressed_q;
    assign rw          = rw_q;
endmodule
